imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous instruction memory (1-cycle read latency) between the
//  fetch stage and a program loader (UART/JTAG side).
//  Sits between the fetch cycle logic and the instruction memory macro.
//  Muxes address/data/write-enable and routes read data back to the owner of each access.
//  Generates the fetch stall, and sequences a halt/load/resume protocol that flushes the pipeline.
// PARAMETERS
//  ADDR_W        9   instruction memory address width
//  DATA_W        34  instruction word width
//  STARVE_LIMIT  8   consecutive cycles loader may wait in RUN before a forced grant (>=1)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-low
//  fetch_req   in   1       fetch wants a read at fetch_addr this cycle
//  fetch_addr  in   ADDR_W  fetch read address (PC)
//  fetch_stall out  1       hold PC and fetch/decode register this cycle
//  fetch_valid out  1       fetch_rdata valid (read granted previous cycle)
//  fetch_rdata out  DATA_W  instruction returned to fetch
//  pipe_flush  out  1       one-cycle pulse on resume: flush pipeline, PC<=0
//  ld_halt     in   1       loader requests exclusive memory ownership
//  ld_halted   out  1       exclusive ownership active (state LOAD)
//  ld_req      in   1       loader access request
//  ld_we       in   1       1=write, 0=read
//  ld_addr     in   ADDR_W  loader address
//  ld_wdata    in   DATA_W  loader write data
//  ld_gnt      out  1       loader access accepted this cycle
//  ld_rvalid   out  1       ld_rdata valid (loader read granted previous cycle)
//  ld_rdata    out  DATA_W  read data to loader
//  mem_addr    out  ADDR_W  to memory address (combinational from winner)
//  mem_we      out  1       to memory write enable
//  mem_wdata   out  DATA_W  to memory write data
//  mem_rdata   in   DATA_W  from memory q (valid 1 cycle after address)
//  stall_cnt   out  16      fetch stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, owner_q=NONE; all outputs 0 (fetch_stall=0, fetch_valid=0,
//   ld_gnt=0, ld_rvalid=0, ld_halted=0, pipe_flush=0, mem_we=0, mem_addr=0, stall_cnt=0).
//  One access per cycle. Winner is combinational.
//   ld_gnt / fetch_stall are combinational from the current state and requests.
//   owner_q <= {FETCH, LOAD_RD, NONE} registered on clk.
//   Writes set owner_q=NONE.
//  Read return: fetch_valid = (owner_q==FETCH); ld_rvalid = (owner_q==LOAD_RD).
//   fetch_rdata and ld_rdata both = mem_rdata.
//  FSM:
//   RUN:    fetch_req has priority.
//           Loader is granted when fetch_req=0, or when wait_cnt==STARVE_LIMIT
//           (forced slot: fetch_stall=1 that cycle).
//           wait_cnt increments while ld_req && !ld_gnt; clears on ld_gnt or ld_req=0.
//           ld_halt=1 -> DRAIN.
//   DRAIN:  no grants to either side; fetch_stall=fetch_req; lets the in-flight read return.
//           Next state is LOAD.
//   LOAD:   ld_halted=1. Loader is granted whenever ld_req=1.
//           fetch_stall=fetch_req; fetch is never granted.
//           ld_halt=0 && owner_q!=LOAD_RD -> RESUME.
//           If a loader read is still in flight, stay in LOAD one more cycle.
//   RESUME: pipe_flush=1 for exactly 1 cycle; no grants; -> RUN.
//  ld_halt drop in DRAIN: DRAIN still goes to LOAD, then exits per the LOAD rule
//   (min 3-cycle halt episode).
//  ld_req with ld_halt in RUN: arbitrated normally until the transition to DRAIN.
//  mem_we=1 only when the loader is granted with ld_we=1; otherwise mem_wdata=0.
//  No-grant cycle: mem_addr holds the previous value (registered last_addr) to avoid toggling.
//  Async reset mid-transfer: any in-flight read is discarded (no valid after reset release);
//   FSM returns to RUN without a pipe_flush pulse.
// CONFIGURATION
//  IMEM_ARB_STALL_CNT_EN defined:
//   stall_cnt increments on every cycle with fetch_stall=1.
//   Saturates at 16'hFFFF; cleared by rst only.
//  Not defined: stall_cnt tied to 16'h0; no counter flops synthesized.
// TESTING
//  1. Reset, fetch_req=1 addr 0,4,8; mem model returns addr*2
//     -> fetch_valid each cycle after the first, rdata 0,8,16; fetch_stall=0.
//  2. RUN, fetch_req=1 steady, ld_req=1 read addr 12
//     -> ld_gnt at cycle 9 (STARVE_LIMIT=8); fetch_stall=1 that cycle; ld_rvalid next cycle, data 24.
//  3. ld_halt=1 during fetch stream -> DRAIN 1 cycle (fetch_valid for last grant), then ld_halted=1;
//     write addr 0..3 data 34'h3_0000_0001.. -> mem_we=1, each ld_gnt same cycle.
//  4. Drop ld_halt in LOAD with a loader read in flight -> one extra LOAD cycle, RESUME,
//     pipe_flush high exactly 1 cycle, RUN resumes fetch grants.
//  5. Assert rst=0 mid-LOAD with a read in flight -> all outputs 0 immediately;
//     after release, no ld_rvalid and no pipe_flush.
//  6. With IMEM_ARB_STALL_CNT_EN: force 10 stall cycles -> stall_cnt=10;
//     preload near 16'hFFFF via long halt -> saturates. Without the macro -> stall_cnt stays 0.

Source files
------------

// File: rtl/imem_arb_if.sv
// Bundle between the fetch stage, the program loader, the instruction memory macro and imem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface imem_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 34
);
  // Handshake: fetch_req and ld_req are level requests held by their owners. An access is
  // taken in the cycle it is granted (fetch: fetch_req && !fetch_stall; loader: ld_req &&
  // ld_gnt). Read data returns one cycle later, qualified by fetch_valid or ld_rvalid.
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              pipe_flush;
  logic              ld_halt;
  logic              ld_halted;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_halt, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output fetch_stall, fetch_valid, fetch_rdata, pipe_flush, ld_halted, ld_gnt,
           ld_rvalid, ld_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_halt, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  fetch_stall, fetch_valid, fetch_rdata, pipe_flush, ld_halted, ld_gnt,
           ld_rvalid, ld_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch and the program loader, with a
// halt/drain/load/resume sequence. Define IMEM_ARB_STALL_CNT_EN to build the fetch stall counter.
module imem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 34,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  imem_arb_if.slave   bus,
  output logic [15:0] stall_cnt,
  output logic [1:0]  fsm_state
);
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  localparam logic [1:0] OWN_NONE    = 2'd0;
  localparam logic [1:0] OWN_FETCH   = 2'd1;
  localparam logic [1:0] OWN_LOAD_RD = 2'd2;

  localparam int              WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              fetch_gnt, ld_gnt, forced;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;

  // Grants are gated by rst so every output reads 0 as soon as reset asserts.
  always_comb begin
    forced     = 1'b0;
    fetch_gnt  = 1'b0;
    ld_gnt     = 1'b0;
    state_d    = state_q;
    wait_cnt_d = '0;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          forced    = bus.ld_req && (wait_cnt_q == WAIT_MAX);
          fetch_gnt = bus.fetch_req && !forced;
          ld_gnt    = bus.ld_req && !fetch_gnt;
          if (bus.ld_req && !ld_gnt) wait_cnt_d = wait_cnt_q + 1'b1;
          if (bus.ld_halt) state_d = ST_DRAIN;
        end
        ST_DRAIN: state_d = ST_LOAD;
        ST_LOAD: begin
          ld_gnt = bus.ld_req;
          // A loader read issued last cycle must return before we leave LOAD.
          if (!bus.ld_halt && (owner_q != OWN_LOAD_RD)) state_d = ST_RESUME;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (fetch_gnt)                  owner_d = OWN_FETCH;
    else if (ld_gnt && !bus.ld_we)  owner_d = OWN_LOAD_RD;
    // Idle cycles replay the last address so the macro's address pins stay quiet.
    mem_addr = last_addr_q;
    if (fetch_gnt)   mem_addr = bus.fetch_addr;
    else if (ld_gnt) mem_addr = bus.ld_addr;
    mem_we      = ld_gnt && bus.ld_we;
    last_addr_d = mem_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign bus.mem_addr    = mem_addr;
  assign bus.mem_we      = mem_we;
  assign bus.mem_wdata   = mem_we ? bus.ld_wdata : '0;
  assign bus.ld_gnt      = ld_gnt;
  assign bus.fetch_stall = rst && bus.fetch_req && !fetch_gnt;
  assign bus.fetch_valid = (owner_q == OWN_FETCH);
  assign bus.ld_rvalid   = (owner_q == OWN_LOAD_RD);
  assign bus.fetch_rdata = bus.mem_rdata;
  assign bus.ld_rdata    = bus.mem_rdata;
  assign bus.ld_halted   = (state_q == ST_LOAD);
  assign bus.pipe_flush  = (state_q == ST_RESUME);
  assign fsm_state       = state_q;

`ifdef IMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.fetch_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 16'h0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0;
`endif
endmodule
